// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak controller and its downstream stages.
package keccak_pkg;

    localparam int unsigned HASH_WORD_W  = 32;
    localparam int unsigned DIGEST_WORDS = 8;
    localparam int unsigned HASH_NUM_W   = 5;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StCheck,
        StDone
    } collect_state_t;

endpackage

// File: rtl/digest_cmp.sv
// Registered unsigned a <= b comparator, one cycle of latency.
// Kept separate so the wide compare can be pipelined later for timing.
module digest_cmp #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             le
);

    // Capture the compare result only when enabled; hold it otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            le <= 1'b0;
        end else if (en) begin
            le <= (a <= b);
        end
    end

endmodule

// File: rtl/keccak_digest_collector.sv
// Collects 32-bit hash words into a digest (first word in the MS slot), compares it
// against a target and holds digest/tag/hit until the consumer acknowledges.
module keccak_digest_collector
    import keccak_pkg::*;
#(
    parameter int unsigned WORDS = DIGEST_WORDS,
    parameter int unsigned TAGW  = HASH_NUM_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [TAGW-1:0]              hash_num,
    input  logic [HASH_WORD_W*WORDS-1:0] target,
    input  logic                         word_valid,
    input  logic [HASH_WORD_W-1:0]       word_in,
    output logic                         word_ready,
    output logic [HASH_WORD_W*WORDS-1:0] digest,
    output logic [TAGW-1:0]              digest_tag,
    output logic                         digest_valid,
    output logic                         hit,
    input  logic                         digest_ack,
    output logic                         busy,
    output logic                         err
);

    localparam int unsigned DW = HASH_WORD_W * WORDS;
    localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    collect_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  digest_q, digest_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic           err_q, err_d;

    // State, counter, digest, tag and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            digest_q <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digest_q <= digest_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic and word placement; ready is a pure state decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        digest_d   = digest_q;
        tag_d      = tag_q;
        word_ready = (state_q == StCollect);
        err_d      = err_q | (word_valid & ~word_ready);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StCollect;
                    cnt_d    = '0;
                    digest_d = '0;
                    tag_d    = hash_num;
                end
            end
            StCollect: begin
                if (start) begin
                    // Abort: restart, dropping any word offered this cycle.
                    cnt_d    = '0;
                    digest_d = '0;
                    tag_d    = hash_num;
                end else if (word_valid) begin
                    for (int unsigned i = 0; i < WORDS; i++) begin
                        if (cnt_q == CW'(i)) begin
                            digest_d[DW-1-HASH_WORD_W*i -: HASH_WORD_W] = word_in;
                        end
                    end
                    if (cnt_q == CW'(WORDS - 1)) begin
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StCheck: begin
                state_d = StDone;
            end
            StDone: begin
                if (digest_ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    digest_cmp #(
        .WIDTH (DW)
    ) u_cmp (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == StCheck),
        .a     (digest_q),
        .b     (target),
        .le    (hit)
    );

    // Output decode.
    always_comb begin
        digest       = digest_q;
        digest_tag   = tag_q;
        digest_valid = (state_q == StDone);
        busy         = (state_q != StIdle);
        err          = err_q;
    end

endmodule

// File: tb/tb_keccak_digest_collector.sv
// Directed, table-driven bench for keccak_digest_collector.
module tb_keccak_digest_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   hash_num;
    logic [255:0] target;
    logic         word_valid;
    logic [31:0]  word_in;
    logic         word_ready;
    logic [255:0] digest;
    logic [4:0]   digest_tag;
    logic         digest_valid;
    logic         hit;
    logic         digest_ack;
    logic         busy;
    logic         err;

    int total = 0;
    int bad   = 0;

    keccak_digest_collector #(
        .WORDS (8),
        .TAGW  (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .hash_num     (hash_num),
        .target       (target),
        .word_valid   (word_valid),
        .word_in      (word_in),
        .word_ready   (word_ready),
        .digest       (digest),
        .digest_tag   (digest_tag),
        .digest_valid (digest_valid),
        .hit          (hit),
        .digest_ack   (digest_ack),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   tag;
        logic [31:0]  base;
        logic [31:0]  stp;
        logic [255:0] tgt;
        logic [255:0] exp_digest;
        logic         exp_hit;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed 8 words (optionally gapped), then check CHECK/DONE timing.
    task automatic send_words(input logic [31:0] base, input logic [31:0] stp, input bit gapped);
        int n = 0;
        int cyc = 0;
        while (n < 8 && cyc < 64) begin
            if (gapped && (cyc % 2 == 1)) begin
                word_valid = 1'b0;
                word_in    = 32'hBAD0_0000 | 32'(cyc);
            end else begin
                word_valid = 1'b1;
                word_in    = base + stp * 32'(n);
                n++;
            end
            tick();
            cyc++;
        end
        word_valid = 1'b0;
        check("dv_low_in_check", {255'd0, digest_valid}, 256'd0);
        check("busy_in_check", {255'd0, busy}, 256'd1);
        tick();
        check("dv_high_after_check", {255'd0, digest_valid}, 256'd1);
    endtask

    task automatic collect(input logic [4:0] tag, input logic [31:0] base,
                           input logic [31:0] stp, input bit gapped);
        start    = 1'b1;
        hash_num = tag;
        tick();
        start    = 1'b0;
        check("ready_after_start", {255'd0, word_ready}, 256'd1);
        check("busy_after_start", {255'd0, busy}, 256'd1);
        send_words(base, stp, gapped);
    endtask

    task automatic ack();
        digest_ack = 1'b1;
        tick();
        digest_ack = 1'b0;
        check("dv_after_ack", {255'd0, digest_valid}, 256'd0);
        check("busy_after_ack", {255'd0, busy}, 256'd0);
    endtask

    initial begin
        vecs[0] = '{5'd3, 32'h1, 32'h1, {256{1'b1}},
                    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                    1'b1};
        vecs[1] = '{5'd7, 32'h1, 32'h1,
                    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000007,
                    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                    1'b0};
        vecs[2] = '{5'd12, 32'h1, 32'h1,
                    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                    1'b1};
        vecs[3] = '{5'd31, 32'hFFFF_FFFF, 32'h0, {256{1'b1}}, {256{1'b1}}, 1'b1};
        vecs[4] = '{5'd0, 32'h8000_0000, 32'h1,
                    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff,
                    256'h80000000_80000001_80000002_80000003_80000004_80000005_80000006_80000007,
                    1'b0};
        vecs[5] = '{5'd1, 32'h1, 32'h0,
                    256'h00000002_00000000_00000000_00000000_00000000_00000000_00000000_00000000,
                    256'h00000001_00000001_00000001_00000001_00000001_00000001_00000001_00000001,
                    1'b1};

        reset      = 1'b1;
        start      = 1'b0;
        hash_num   = '0;
        target     = '0;
        word_valid = 1'b0;
        word_in    = '0;
        digest_ack = 1'b0;
        tick();
        tick();
        check("rst_word_ready", {255'd0, word_ready}, 256'd0);
        check("rst_digest", digest, 256'd0);
        check("rst_tag", {251'd0, digest_tag}, 256'd0);
        check("rst_dv", {255'd0, digest_valid}, 256'd0);
        check("rst_hit", {255'd0, hit}, 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_err", {255'd0, err}, 256'd0);
        reset = 1'b0;
        tick();

        // Table of complete collections.
        for (int v = 0; v < 6; v++) begin
            target = vecs[v].tgt;
            collect(vecs[v].tag, vecs[v].base, vecs[v].stp, 1'b0);
            check($sformatf("vec%0d_digest", v), digest, vecs[v].exp_digest);
            check($sformatf("vec%0d_tag", v), {251'd0, digest_tag}, {251'd0, vecs[v].tag});
            check($sformatf("vec%0d_hit", v), {255'd0, hit}, {255'd0, vecs[v].exp_hit});
            check($sformatf("vec%0d_err", v), {255'd0, err}, 256'd0);
            ack();
            tick();
        end

        // Gapped valid.
        target = {256{1'b1}};
        collect(5'd21, 32'h1000, 32'h1, 1'b1);
        check("gap_digest", digest,
              256'h00001000_00001001_00001002_00001003_00001004_00001005_00001006_00001007);
        check("gap_tag", {251'd0, digest_tag}, 256'd21);
        check("gap_err", {255'd0, err}, 256'd0);
        ack();
        tick();

        // Abort after 5 words; the word offered with start is dropped.
        start    = 1'b1;
        hash_num = 5'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            word_valid = 1'b1;
            word_in    = 32'h5555_0000 + 32'(i);
            tick();
        end
        start      = 1'b1;
        hash_num   = 5'd10;
        word_valid = 1'b1;
        word_in    = 32'hDEAD_BEEF;
        tick();
        start      = 1'b0;
        word_valid = 1'b0;
        check("abort_digest_cleared", digest, 256'd0);
        check("abort_tag", {251'd0, digest_tag}, 256'd10);
        check("abort_ready", {255'd0, word_ready}, 256'd1);
        check("abort_err", {255'd0, err}, 256'd0);
        target = 256'hAAAA0000_AAAA0001_AAAA0002_AAAA0003_AAAA0004_AAAA0005_AAAA0006_AAAA0006;
        send_words(32'hAAAA_0000, 32'h1, 1'b0);
        check("abort_final_digest", digest,
              256'hAAAA0000_AAAA0001_AAAA0002_AAAA0003_AAAA0004_AAAA0005_AAAA0006_AAAA0007);
        check("abort_final_tag", {251'd0, digest_tag}, 256'd10);
        check("abort_hit", {255'd0, hit}, 256'd0);

        // Hold for 10 cycles without ack; start pulses are ignored.
        for (int i = 0; i < 10; i++) begin
            start    = (i == 3);
            hash_num = 5'd20;
            tick();
            check("hold_dv", {255'd0, digest_valid}, 256'd1);
            check("hold_digest", digest,
                  256'hAAAA0000_AAAA0001_AAAA0002_AAAA0003_AAAA0004_AAAA0005_AAAA0006_AAAA0007);
            check("hold_tag", {251'd0, digest_tag}, 256'd10);
            check("hold_hit", {255'd0, hit}, 256'd0);
        end
        start      = 1'b1;
        digest_ack = 1'b1;
        tick();
        start      = 1'b0;
        digest_ack = 1'b0;
        check("ackstart_dv", {255'd0, digest_valid}, 256'd0);
        check("ackstart_busy", {255'd0, busy}, 256'd0);
        check("ackstart_ready", {255'd0, word_ready}, 256'd0);
        check("digest_kept_after_ack", digest,
              256'hAAAA0000_AAAA0001_AAAA0002_AAAA0003_AAAA0004_AAAA0005_AAAA0006_AAAA0007);
        tick();
        check("idle_stays_idle", {255'd0, busy}, 256'd0);

        // Word in IDLE sets a sticky error.
        word_valid = 1'b1;
        word_in    = 32'h1234_0000;
        tick();
        word_valid = 1'b0;
        check("err_set", {255'd0, err}, 256'd1);
        tick();
        tick();
        tick();
        check("err_sticky", {255'd0, err}, 256'd1);

        // Asynchronous reset mid-collection.
        start    = 1'b1;
        hash_num = 5'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            word_valid = 1'b1;
            word_in    = 32'h4444_0000 + 32'(i);
            tick();
        end
        word_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_digest", digest, 256'd0);
        check("arst_tag", {251'd0, digest_tag}, 256'd0);
        check("arst_busy", {255'd0, busy}, 256'd0);
        check("arst_ready", {255'd0, word_ready}, 256'd0);
        check("arst_dv", {255'd0, digest_valid}, 256'd0);
        check("arst_err", {255'd0, err}, 256'd0);
        check("arst_hit", {255'd0, hit}, 256'd0);
        #3;
        reset = 1'b0;
        tick();

        target = {256{1'b1}};
        collect(5'd17, 32'h1234_5678, 32'h1111_1111, 1'b0);
        check("post_rst_digest", digest,
              256'h12345678_23456789_3456789A_456789AB_56789ABC_6789ABCD_789ABCDE_89ABCDEF);
        check("post_rst_tag", {251'd0, digest_tag}, 256'd17);
        check("post_rst_hit", {255'd0, hit}, 256'd1);
        check("post_rst_err", {255'd0, err}, 256'd0);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
